// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide: MUL_BITS multiplier bits or 1 quotient bit per cycle.
// valid/ready accept only when idle; one-cycle valid_o pulse, no output backpressure; flush_i kills the op.
module mdu_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  localparam int MUL_CYC = XLEN / MUL_BITS;
  localparam int CW      = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state_q;
  logic [1:0]        op_q;
  logic              neg_q, neg_rem_q;
  logic [2*XLEN-1:0] mcand_q, acc_q, acc_nxt, prod;
  logic [XLEN-1:0]   mplier_q, divisor_q, rem_q, quo_q;
  logic [XLEN-1:0]   rem_nxt, quo_nxt, quo_fix, rem_fix;
  logic [XLEN:0]     trial, diff;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   stage_q, result_q;

  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, accept, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  always_comb begin
    is_div   = op_i[2];
    a_sgn    = is_div ? !op_i[0] : (op_i[1:0] != 2'b11);
    b_sgn    = is_div ? !op_i[0] : !op_i[1];
    a_neg    = a_sgn & a_i[XLEN-1];
    b_neg    = b_sgn & b_i[XLEN-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
    fast     = 1'b0;
    fast_res = '1;
    if (b_i == '0) begin
      fast     = 1'b1;
      fast_res = op_i[1] ? a_i : '1;
    end else if (!op_i[0] && a_i == MOST_NEG && b_i == '1) begin
      fast     = 1'b1;
      fast_res = op_i[1] ? '0 : a_i;
    end
    accept = valid_i && (state_q == IDLE) && !flush_i;
  end

  always_comb begin
    acc_nxt = acc_q + mcand_q * {{(2*XLEN-MUL_BITS){1'b0}}, mplier_q[MUL_BITS-1:0]};
    prod    = neg_q ? -acc_nxt : acc_nxt;
    // Restoring step: a borrow out of the trial subtract means keep the shifted remainder.
    trial   = {rem_q, quo_q[XLEN-1]};
    diff    = trial - {1'b0, divisor_q};
    rem_nxt = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    quo_nxt = {quo_q[XLEN-2:0], !diff[XLEN]};
    quo_fix = neg_q ? -quo_nxt : quo_nxt;
    rem_fix = neg_rem_q ? -rem_nxt : rem_nxt;
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = !ready_o;
  assign valid_o  = (state_q == DONE) && !flush_i && !rst_i;
  assign result_o = valid_o ? stage_q : result_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      stage_q   <= '0;
      result_q  <= '0;
    end else if (flush_i && state_q != IDLE) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q      <= op_i[1:0];
          neg_q     <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          acc_q     <= '0;
          mcand_q   <= {{XLEN{1'b0}}, a_mag};
          mplier_q  <= b_mag;
          divisor_q <= b_mag;
          rem_q     <= '0;
          quo_q     <= a_mag;
          if (!is_div) begin
            state_q <= MUL;
            cnt_q   <= CW'(MUL_CYC - 1);
          end else if (fast) begin
            state_q <= DONE;
            stage_q <= fast_res;
          end else begin
            state_q <= DIV;
            cnt_q   <= CW'(XLEN - 1);
          end
        end
        MUL: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << MUL_BITS;
          mplier_q <= mplier_q >> MUL_BITS;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= DONE;
            stage_q <= (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          end
        end
        DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= DONE;
            stage_q <= op_q[1] ? rem_fix : quo_fix;
          end
        end
        DONE: begin
          result_q <= stage_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
